apb_gpio_arbiter: RTL and testbench

Two-requester arbiter and APB requester FSM that shares one APB peripheral port (the GPIO block) between two on-chip requesters, e.g. core load/store unit and a DMA/pattern sequencer. Each requester issues single read/write transactions over a simple req/done interface. The block arbitrates round-robin, sequences the APB SETUP/ACCESS phases, and returns read data or error to the owner. Sits between the system interconnect and apb_gpio, in the pclk domain.

---
 rtl/apb_gpio_arbiter_if.sv | 24 ++
 rtl/apb_gpio_arbiter.sv | 159 +++++++++++++++
 tb/tb_apb_gpio_arbiter.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_gpio_arbiter_if.sv
// APB bus bundle between the GPIO requester arbiter (master) and the apb_gpio peripheral (slave).
interface apb_gpio_arbiter_if #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32
);
  logic [ADDRESS_WIDTH-1:0] paddr;
  logic                     psel;
  logic                     penable;
  logic                     pwrite;
  logic [DATA_WIDTH-1:0]    pwdata;
  logic                     pready;
  logic [DATA_WIDTH-1:0]    prdata;
  logic                     pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/apb_gpio_arbiter.sv
// Round-robin arbiter sharing one APB port (apb_gpio) between two req/done requesters.
// Optional ACCESS timeout abort is built only when APB_GPIO_ARB_TIMEOUT_EN is defined.
module apb_gpio_arbiter #(
  parameter int ADDRESS_WIDTH  = 5,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                     pclk,
  input  logic                     presetn,

  input  logic                     m0_req_i,
  input  logic                     m0_write_i,
  input  logic [ADDRESS_WIDTH-1:0] m0_addr_i,
  input  logic [DATA_WIDTH-1:0]    m0_wdata_i,
  output logic                     m0_done_o,
  output logic [DATA_WIDTH-1:0]    m0_rdata_o,
  output logic                     m0_err_o,

  input  logic                     m1_req_i,
  input  logic                     m1_write_i,
  input  logic [ADDRESS_WIDTH-1:0] m1_addr_i,
  input  logic [DATA_WIDTH-1:0]    m1_wdata_i,
  output logic                     m1_done_o,
  output logic [DATA_WIDTH-1:0]    m1_rdata_o,
  output logic                     m1_err_o,

  apb_gpio_arbiter_if.master       apb,

  output logic                     busy_o
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                   state;
  logic                     owner;
  logic                     last_grant;

  logic                     winner;
  logic [ADDRESS_WIDTH-1:0] sel_addr;
  logic                     sel_write;
  logic [DATA_WIDTH-1:0]    sel_wdata;
  logic                     timeout_hit;
  logic                     access_end;
  logic                     resp_err;
  logic                     take_rdata;

  // On a tie the requester that did not win last time gets the bus.
  always_comb begin
    winner = m1_req_i;
    if (m0_req_i && m1_req_i) begin
      winner = ~last_grant;
    end
    sel_addr  = winner ? m1_addr_i  : m0_addr_i;
    sel_write = winner ? m1_write_i : m0_write_i;
    sel_wdata = winner ? m1_wdata_i : m0_wdata_i;
  end

`ifdef APB_GPIO_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tcount;
  assign timeout_hit = !apb.pready && (tcount == CW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
`endif

  // A timed-out access reports an error and leaves the read data untouched.
  assign access_end = apb.pready || timeout_hit;
  assign resp_err   = apb.pready ? apb.pslverr : 1'b1;
  assign take_rdata = apb.pready && !apb.pwrite;

  // The APB output registers double as the captured request fields for the transfer.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last_grant  <= 1'b1;
      busy_o      <= 1'b0;
      apb.psel    <= 1'b0;
      apb.penable <= 1'b0;
      apb.pwrite  <= 1'b0;
      apb.paddr   <= '0;
      apb.pwdata  <= '0;
      m0_done_o   <= 1'b0;
      m0_err_o    <= 1'b0;
      m0_rdata_o  <= '0;
      m1_done_o   <= 1'b0;
      m1_err_o    <= 1'b0;
      m1_rdata_o  <= '0;
`ifdef APB_GPIO_ARB_TIMEOUT_EN
      tcount      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (m0_req_i || m1_req_i) begin
            state       <= SETUP;
            owner       <= winner;
            last_grant  <= winner;
            busy_o      <= 1'b1;
            apb.psel    <= 1'b1;
            apb.penable <= 1'b0;
            apb.paddr   <= sel_addr;
            apb.pwrite  <= sel_write;
            apb.pwdata  <= sel_wdata;
`ifdef APB_GPIO_ARB_TIMEOUT_EN
            tcount      <= '0;
`endif
          end
        end

        SETUP: begin
          state       <= ACCESS;
          apb.penable <= 1'b1;
        end

        ACCESS: begin
          if (access_end) begin
            state       <= RESP;
            apb.psel    <= 1'b0;
            apb.penable <= 1'b0;
            apb.pwrite  <= 1'b0;
            apb.paddr   <= '0;
            apb.pwdata  <= '0;
            if (owner == 1'b0) begin
              m0_done_o <= 1'b1;
              m0_err_o  <= resp_err;
              if (take_rdata) begin
                m0_rdata_o <= apb.prdata;
              end
            end else begin
              m1_done_o <= 1'b1;
              m1_err_o  <= resp_err;
              if (take_rdata) begin
                m1_rdata_o <= apb.prdata;
              end
            end
          end
`ifdef APB_GPIO_ARB_TIMEOUT_EN
          else begin
            tcount <= tcount + 1'b1;
          end
`endif
        end

        RESP: begin
          state     <= IDLE;
          busy_o    <= 1'b0;
          m0_done_o <= 1'b0;
          m0_err_o  <= 1'b0;
          m1_done_o <= 1'b0;
          m1_err_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_gpio_arbiter.sv
// Directed, table-driven bench for apb_gpio_arbiter plus hand-written arbitration,
// mid-transfer reset and stuck-slave sequences.
module tb_apb_gpio_arbiter;

  logic        pclk;
  logic        presetn;
  logic        m0_req, m0_write, m0_done, m0_err;
  logic [4:0]  m0_addr;
  logic [31:0] m0_wdata, m0_rdata;
  logic        m1_req, m1_write, m1_done, m1_err;
  logic [4:0]  m1_addr;
  logic [31:0] m1_wdata, m1_rdata;
  logic        busy;

  int passCount  = 0;
  int totalCount = 0;
  logic [31:0] rdata_model [2];

  typedef struct {
    int          req_id;
    logic        write;
    logic [4:0]  addr;
    logic [31:0] wdata;
    int          wait_n;
    logic [31:0] prdata;
    logic        pslverr;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [6];

  apb_gpio_arbiter_if #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32)) apb_bus ();

  apb_gpio_arbiter #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .pclk       (pclk),
    .presetn    (presetn),
    .m0_req_i   (m0_req),
    .m0_write_i (m0_write),
    .m0_addr_i  (m0_addr),
    .m0_wdata_i (m0_wdata),
    .m0_done_o  (m0_done),
    .m0_rdata_o (m0_rdata),
    .m0_err_o   (m0_err),
    .m1_req_i   (m1_req),
    .m1_write_i (m1_write),
    .m1_addr_i  (m1_addr),
    .m1_wdata_i (m1_wdata),
    .m1_done_o  (m1_done),
    .m1_rdata_o (m1_rdata),
    .m1_err_o   (m1_err),
    .apb        (apb_bus.master),
    .busy_o     (busy)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    totalCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Drives one transaction and plays the APB slave, inserting wait_n wait states.
  task automatic applyStimulus(input vec_t v);
    int          setup_n   = 0;
    int          access_n  = 0;
    int          done_cyc  = 0;
    logic        got_done  = 1'b0;
    logic        other_hit = 1'b0;
    logic [4:0]  seen_addr = '0;
    logic [31:0] seen_wdata = '0;
    logic        seen_write = 1'b0;
    logic        own_err = 1'b0;
    logic        own_psel = 1'b1;
    logic [31:0] own_rdata = '0;
    logic [31:0] oth_rdata;
    @(posedge pclk); #1;
    if (v.req_id == 0) begin
      m0_req = 1'b1; m0_write = v.write; m0_addr = v.addr; m0_wdata = v.wdata;
    end else begin
      m1_req = 1'b1; m1_write = v.write; m1_addr = v.addr; m1_wdata = v.wdata;
    end
    apb_bus.pready = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge pclk); #1;
      if (apb_bus.psel && !apb_bus.penable) begin
        setup_n++;
        seen_addr  = apb_bus.paddr;
        seen_wdata = apb_bus.pwdata;
        seen_write = apb_bus.pwrite;
      end
      if (apb_bus.psel && apb_bus.penable) begin
        access_n++;
        apb_bus.pready  = (access_n > v.wait_n);
        apb_bus.prdata  = v.prdata;
        apb_bus.pslverr = v.pslverr;
      end else begin
        apb_bus.pready = 1'b0;
      end
      if ((v.req_id == 0) ? m1_done : m0_done) other_hit = 1'b1;
      if ((v.req_id == 0) ? m0_done : m1_done) begin
        got_done  = 1'b1;
        done_cyc  = cyc;
        own_err   = (v.req_id == 0) ? m0_err : m1_err;
        own_rdata = (v.req_id == 0) ? m0_rdata : m1_rdata;
        own_psel  = apb_bus.psel;
        m0_req = 1'b0;
        m1_req = 1'b0;
        break;
      end
    end
    oth_rdata = (v.req_id == 0) ? m1_rdata : m0_rdata;
    checkOutput("vec_done_seen", 32'(got_done), 32'd1);
    checkOutput("vec_done_latency", done_cyc, v.wait_n + 3);
    checkOutput("vec_setup_cycles", setup_n, 1);
    checkOutput("vec_access_cycles", access_n, v.wait_n + 1);
    checkOutput("vec_paddr", 32'(seen_addr), 32'(v.addr));
    checkOutput("vec_pwrite", 32'(seen_write), 32'(v.write));
    if (v.write) checkOutput("vec_pwdata", seen_wdata, v.wdata);
    checkOutput("vec_err", 32'(own_err), 32'(v.exp_err));
    checkOutput("vec_rdata", own_rdata, v.exp_rdata);
    checkOutput("vec_psel_in_resp", 32'(own_psel), 32'd0);
    checkOutput("vec_other_done", 32'(other_hit), 32'd0);
    checkOutput("vec_other_rdata", oth_rdata, rdata_model[1 - v.req_id]);
    rdata_model[v.req_id] = v.exp_rdata;
    @(posedge pclk); #1;
    checkOutput("vec_done_cleared", 32'({m0_done, m1_done}), 32'd0);
    checkOutput("vec_err_cleared", 32'({m0_err, m1_err}), 32'd0);
    checkOutput("vec_busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    int          ns;
    int          m0_dones;
    int          m1_dones;
    int          acc;
    int          setup_cyc [3];
    logic [4:0]  sa [3];
    logic        sw [3];
    logic [31:0] swd [3];
    logic        got;
    logic        flag;
    logic        t_err;
    logic        t_psel;
    logic [31:0] t_rdata;

    vecs[0] = '{0, 1'b1, 5'h04, 32'h000000A5, 0, 32'hBAD0BAD0, 1'b0, 1'b0, 32'h00000000};
    vecs[1] = '{1, 1'b0, 5'h14, 32'h00000000, 3, 32'h00000011, 1'b0, 1'b0, 32'h00000011};
    vecs[2] = '{0, 1'b1, 5'h0C, 32'h00001234, 0, 32'hBAD0BAD0, 1'b1, 1'b1, 32'h00000000};
    vecs[3] = '{0, 1'b0, 5'h08, 32'h00000000, 1, 32'hDEADBEEF, 1'b0, 1'b0, 32'hDEADBEEF};
    vecs[4] = '{0, 1'b0, 5'h10, 32'h00000000, 0, 32'h5A5A0001, 1'b1, 1'b1, 32'h5A5A0001};
    vecs[5] = '{1, 1'b1, 5'h1F, 32'hFFFFFFFF, 0, 32'hBAD0BAD0, 1'b0, 1'b0, 32'h00000011};
    rdata_model[0] = '0;
    rdata_model[1] = '0;

    presetn = 1'b0;
    m0_req = 1'b0; m0_write = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_write = 1'b0; m1_addr = '0; m1_wdata = '0;
    apb_bus.pready = 1'b0; apb_bus.prdata = '0; apb_bus.pslverr = 1'b0;
    $display("[TB] starting apb_gpio_arbiter bench");
    repeat (2) @(posedge pclk);
    #1;
    checkOutput("rst_psel", 32'(apb_bus.psel), 32'd0);
    checkOutput("rst_penable", 32'(apb_bus.penable), 32'd0);
    checkOutput("rst_pwrite", 32'(apb_bus.pwrite), 32'd0);
    checkOutput("rst_paddr", 32'(apb_bus.paddr), 32'd0);
    checkOutput("rst_pwdata", apb_bus.pwdata, 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'({m0_done, m1_done}), 32'd0);
    checkOutput("rst_err", 32'({m0_err, m1_err}), 32'd0);
    checkOutput("rst_m0_rdata", m0_rdata, 32'd0);
    checkOutput("rst_m1_rdata", m1_rdata, 32'd0);
    presetn = 1'b1;

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i]);
    end

    // Both requesters raise and hold req together: expect m0, m1, m0 back to back.
    ns = 0; m0_dones = 0; m1_dones = 0;
    @(posedge pclk); #1;
    m0_req = 1'b1; m0_write = 1'b0; m0_addr = 5'h08; m0_wdata = '0;
    m1_req = 1'b1; m1_write = 1'b1; m1_addr = 5'h00; m1_wdata = 32'hFFFF0000;
    apb_bus.pready = 1'b1; apb_bus.prdata = 32'h00000077; apb_bus.pslverr = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge pclk); #1;
      if (apb_bus.psel && !apb_bus.penable && ns < 3) begin
        setup_cyc[ns] = cyc;
        sa[ns]  = apb_bus.paddr;
        sw[ns]  = apb_bus.pwrite;
        swd[ns] = apb_bus.pwdata;
        ns++;
      end
      if (m0_done) m0_dones++;
      if (m1_done) m1_dones++;
      if (m0_dones == 2) begin
        m0_req = 1'b0;
        m1_req = 1'b0;
        break;
      end
    end
    apb_bus.pready = 1'b0;
    checkOutput("rr_m0_dones", m0_dones, 2);
    checkOutput("rr_m1_dones", m1_dones, 1);
    checkOutput("rr_grants", ns, 3);
    checkOutput("rr_first_addr", 32'(sa[0]), 32'h08);
    checkOutput("rr_first_write", 32'(sw[0]), 32'd0);
    checkOutput("rr_second_addr", 32'(sa[1]), 32'h00);
    checkOutput("rr_second_write", 32'(sw[1]), 32'd1);
    checkOutput("rr_second_wdata", swd[1], 32'hFFFF0000);
    checkOutput("rr_third_addr", 32'(sa[2]), 32'h08);
    checkOutput("rr_gap_1", setup_cyc[1] - setup_cyc[0], 4);
    checkOutput("rr_gap_2", setup_cyc[2] - setup_cyc[1], 4);
    checkOutput("rr_m0_rdata", m0_rdata, 32'h00000077);
    checkOutput("rr_m1_rdata", m1_rdata, 32'h00000011);
    rdata_model[0] = 32'h00000077;
    @(posedge pclk); #1;

    // Reset during ACCESS of an m0 write aborts it without a done pulse.
    got = 1'b0; flag = 1'b0;
    @(posedge pclk); #1;
    m0_req = 1'b1; m0_write = 1'b1; m0_addr = 5'h18; m0_wdata = 32'hCAFEF00D;
    apb_bus.pready = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(posedge pclk); #1;
      if (apb_bus.psel && apb_bus.penable) begin
        got = 1'b1;
        break;
      end
    end
    checkOutput("rst_mid_access_reached", 32'(got), 32'd1);
    presetn = 1'b0;
    #1;
    checkOutput("rst_mid_psel", 32'(apb_bus.psel), 32'd0);
    checkOutput("rst_mid_penable", 32'(apb_bus.penable), 32'd0);
    checkOutput("rst_mid_busy", 32'(busy), 32'd0);
    m0_req = 1'b0;
    repeat (2) begin
      @(posedge pclk); #1;
      if (m0_done) flag = 1'b1;
    end
    checkOutput("rst_mid_no_done", 32'(flag), 32'd0);
    presetn = 1'b1;
    checkOutput("rst_mid_m0_rdata", m0_rdata, 32'd0);
    checkOutput("rst_mid_m1_rdata", m1_rdata, 32'd0);
    rdata_model[0] = '0;
    rdata_model[1] = '0;
    applyStimulus('{0, 1'b1, 5'h18, 32'hCAFEF00D, 0, 32'hBAD0BAD0, 1'b0, 1'b0, 32'h00000000});

    // Slave never raises pready.
    acc = 0; got = 1'b0; t_err = 1'b0; t_psel = 1'b1; t_rdata = '0;
    @(posedge pclk); #1;
    m0_req = 1'b1; m0_write = 1'b0; m0_addr = 5'h04; m0_wdata = '0;
    apb_bus.pready = 1'b0; apb_bus.prdata = 32'hFFFFFFFF;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(posedge pclk); #1;
      if (apb_bus.psel && apb_bus.penable) acc++;
      if (m0_done) begin
        got = 1'b1;
        t_err = m0_err;
        t_rdata = m0_rdata;
        t_psel = apb_bus.psel;
        m0_req = 1'b0;
        break;
      end
    end
`ifdef APB_GPIO_ARB_TIMEOUT_EN
    checkOutput("tmo_done", 32'(got), 32'd1);
    checkOutput("tmo_access_cycles", acc, 16);
    checkOutput("tmo_err", 32'(t_err), 32'd1);
    checkOutput("tmo_rdata_kept", t_rdata, rdata_model[0]);
    checkOutput("tmo_psel_dropped", 32'(t_psel), 32'd0);
    @(posedge pclk); #1;
    checkOutput("tmo_err_cleared", 32'(m0_err), 32'd0);
`else
    checkOutput("stuck_no_done", 32'(got), 32'd0);
    checkOutput("stuck_psel", 32'(apb_bus.psel), 32'd1);
    checkOutput("stuck_penable", 32'(apb_bus.penable), 32'd1);
    checkOutput("stuck_access_cycles", acc, 39);
    m0_req = 1'b0;
    presetn = 1'b0;
    #1;
    presetn = 1'b1;
`endif

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
